score_scan_ctrl: RTL and testbench
==================================

# score_scan_ctrl

Time-multiplexing controller that shares one registered seven-segment score decoder between the two player score digits of the pong display. It holds frame-coherent copies of both scores and scans digit slots with a blanking gap that covers the decoder's one-cycle latency. On game over it flashes the winner's digit. It sits between the score-keeping logic and the decoder/digit-enable pins.

## Interface
- REFRESH_DIV, 50000, clock cycles per digit slot; must be > BLANK_CYCLES
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits disabled; must be >= 2
- FLASH_FRAMES, 64, full frames (both slots) per flash half-period
- i_clk  input  1  system clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_p1_score  input  4  player 1 score; values > 9 saturate to 9
- i_p2_score  input  4  player 2 score; values > 9 saturate to 9
- i_score_load  input  1  single-cycle strobe; captures both score inputs
- i_game_over  input  1  level; high enables winner flashing
- o_score  output  4  digit value driven to the registered decoder (0–9)
- o_digit_en  output  2  active-high digit enables; bit0 = P1, bit1 = P2; at most one bit high
- o_frame_done  output  1  one-cycle pulse on the last cycle of slot 1

## Operation
- Registers:
  - slot counter cnt, range 0..REFRESH_DIV-1
  - slot bit, 0 = P1, 1 = P2
  - pending scores pend1/pend2
  - active scores act1/act2
  - winner[1:0]
  - flash frame counter
  - flash_phase, 1 = visible
- Slot phases, derived from cnt:
  - BLANK (cnt < BLANK_CYCLES): o_digit_en = 00.
  - SHOW (cnt >= BLANK_CYCLES): o_digit_en = one-hot(slot), ANDed with the visibility mask.
- Slot end: at cnt == REFRESH_DIV-1, cnt wraps to 0 and slot toggles.
- o_score is registered. It takes the new slot's active score on the first BLANK cycle, so the decoder output settles before SHOW.
- Frame boundary is the slot 1 → slot 0 transition. On it, act1/act2 <= pend1/pend2.
- Score load:
  - i_score_load writes saturated inputs to pend1/pend2.
  - Multiple loads within one frame: last wins.
  - A load in the boundary cycle bypasses pending. The strobed values go straight to active and pending, so they are shown in the new frame.
- Active scores never change mid-frame.
- Game over:
  - On the first cycle i_game_over is sampled high after being low, latch winner from act1/act2: act1 > act2 → 01; act2 > act1 → 10; equal → 11.
  - While i_game_over is high, the flash counter counts frame boundaries. Every FLASH_FRAMES boundaries, flash_phase toggles and the counter clears.
  - Visibility mask = ~(winner & {2{~flash_phase}}). Non-winning digits stay lit.
  - When i_game_over is low: winner = 00, flash_phase = 1, flash counter = 0.
- Score loads during game over are accepted normally. Winner is not recomputed until the next rising edge of i_game_over.

## Timing
- Reset values, one cycle after i_rst sampled high:
  - cnt = 0, slot = 0
  - pend/act = 0, winner = 00, flash_phase = 1, flash counter = 0
  - o_score = 0, o_digit_en = 00, o_frame_done = 0
- Reset mid-slot aborts the slot immediately. The cycle after reset release is cnt = 0 of slot 0 (BLANK).
- Frame length is 2·REFRESH_DIV cycles. o_digit_en first goes high BLANK_CYCLES cycles after reset release.
- o_digit_en changes only on BLANK/SHOW edges or on flash toggles. Flash toggles coincide with a frame boundary, i.e. during BLANK, so no partial-slot flicker.
- Score-load latency:
  - A load strobe in frame N (not the boundary cycle) appears on o_score at the first slot-0 BLANK cycle of frame N+1.
  - A load in the boundary cycle appears in that same next frame.
- o_frame_done asserts on cnt == REFRESH_DIV-1 with slot = 1, concurrently with the wrap.
- Game-over winner latch takes effect for masking from the cycle after the rising edge is sampled. The first toggle to invisible occurs FLASH_FRAMES boundaries later.

## Test plan
Parameters for all tests: REFRESH_DIV = 8, BLANK_CYCLES = 2, FLASH_FRAMES = 2.

1. **Reset and scan:** release reset → o_digit_en = 00 for cycles 0–1, 01 for cycles 2–7, 00 for 8–9, 10 for 10–15; o_frame_done high at cycle 15 only; o_score = 0 throughout.
2. **Load timing:** strobe i_score_load with p1 = 3, p2 = 7 at cycle 5 → o_score unchanged until cycle 16, then 3 (cycles 16–23), then 7 at cycle 24.
3. **Saturation and last-wins:** strobe p1 = 12, p2 = 4, then p1 = 5, p2 = 15 in the same frame → next frame shows 5 then 9.
4. **Boundary bypass:** strobe p1 = 2, p2 = 6 exactly on an o_frame_done cycle → the following frame shows 2/6.
5. **Winner flash:** act 4/9, raise i_game_over → P1 lit every frame. P2 enable is on for frames 1–2, off for frames 3–4, on for frames 5–6. A tie (5/5) blanks both in the off frames.
6. **Reset mid-operation:** assert i_rst during a SHOW cycle with game over active → next cycle all outputs 00/0, winner cleared; after release, scan restarts at slot 0 with score 0.

Source files
------------

// File: rtl/score_scan_if.sv
// Score scan bus: score-keeping inputs toward the scan controller and the
// decoder / digit-enable outputs back out of it.
interface score_scan_if;
  logic [3:0] i_p1_score;
  logic [3:0] i_p2_score;
  logic       i_score_load;
  logic       i_game_over;
  logic [3:0] o_score;
  logic [1:0] o_digit_en;
  logic       o_frame_done;

  // Driver side: score-keeping logic (or a testbench) feeding the controller
  modport master (
    output i_p1_score,
    output i_p2_score,
    output i_score_load,
    output i_game_over,
    input  o_score,
    input  o_digit_en,
    input  o_frame_done
  );

  // Controller side
  modport slave (
    input  i_p1_score,
    input  i_p2_score,
    input  i_score_load,
    input  i_game_over,
    output o_score,
    output o_digit_en,
    output o_frame_done
  );
endinterface

// File: rtl/score_scan_ctrl.sv
// score_scan_ctrl: time-multiplexes one registered seven-segment decoder
// between the P1 and P2 score digits. Each slot opens with a blanking gap
// that hides the decoder's one-cycle latency. Scores are frame-coherent
// (latched at the slot 1 -> slot 0 boundary), and on game over the winner's
// digit flashes with a period counted in whole frames.
module score_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned FLASH_FRAMES = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  score_scan_if.slave  bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK  = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

  // Slot / scan state
  logic [CW-1:0] cnt;
  logic          slot;

  // Score storage
  logic [3:0]    pend1, pend2;
  logic [3:0]    act1, act2;
  logic [3:0]    score_q;

  // Game-over flashing state
  logic [1:0]    winner;
  logic [FW-1:0] flash_cnt;
  logic          flash_phase;
  logic          go_q;

  // Derived controls
  logic          slot_end;
  logic          boundary;
  logic [3:0]    sat1, sat2;
  logic          go_rise;
  logic [1:0]    en;

  function automatic logic [3:0] sat9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end & slot;
  assign sat1     = sat9(bus.i_p1_score);
  assign sat2     = sat9(bus.i_p2_score);
  assign go_rise  = bus.i_game_over & ~go_q;

  // Slot counter and slot select: count through the slot, wrap and toggle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt  <= '0;
      slot <= 1'b0;
    end else if (slot_end) begin
      cnt  <= '0;
      slot <= ~slot;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  // Pending scores track every load; active scores only move on the frame
  // boundary. A load landing on the boundary cycle is forwarded straight to
  // active so it is not delayed by an extra frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend1 <= '0;
      pend2 <= '0;
      act1  <= '0;
      act2  <= '0;
    end else begin
      if (bus.i_score_load) begin
        pend1 <= sat1;
        pend2 <= sat2;
      end
      if (boundary) begin
        act1 <= bus.i_score_load ? sat1 : pend1;
        act2 <= bus.i_score_load ? sat2 : pend2;
      end
    end
  end

  // Decoder input register: load the upcoming slot's score on the wrap so
  // the decoder has settled by the time the blanking gap ends. Entering
  // slot 0 uses the same value act1 is about to take.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      score_q <= '0;
    end else if (slot_end) begin
      if (slot) begin
        score_q <= bus.i_score_load ? sat1 : pend1;
      end else begin
        score_q <= act2;
      end
    end
  end

  // Game-over tracking: latch the winner on the rising edge, count frame
  // boundaries to toggle the flash phase, clear everything while low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      go_q        <= 1'b0;
      winner      <= 2'b00;
      flash_cnt   <= '0;
      flash_phase <= 1'b1;
    end else begin
      go_q <= bus.i_game_over;
      if (!bus.i_game_over) begin
        winner      <= 2'b00;
        flash_cnt   <= '0;
        flash_phase <= 1'b1;
      end else begin
        if (go_rise) begin
          if (act1 > act2) begin
            winner <= 2'b01;
          end else if (act2 > act1) begin
            winner <= 2'b10;
          end else begin
            winner <= 2'b11;
          end
        end
        if (boundary) begin
          if (flash_cnt == FLASH_LAST) begin
            flash_cnt   <= '0;
            flash_phase <= ~flash_phase;
          end else begin
            flash_cnt   <= flash_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Digit enables: dark during BLANK, one-hot slot during SHOW, with the
  // winner's digit masked while the flash phase is invisible.
  always_comb begin
    en = 2'b00;
    if (cnt >= CNT_BLANK) begin
      en = slot ? 2'b10 : 2'b01;
    end
    en = en & ~(winner & {2{~flash_phase}});
  end

  assign bus.o_score      = score_q;
  assign bus.o_digit_en   = en;
  assign bus.o_frame_done = boundary;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Testbench for score_scan_ctrl: a fixed vector table for the reset/scan and
// load-latency timeline, directed sequences for saturation, boundary bypass,
// flashing and mid-run reset, then randomized traffic against a reference
// model that tracks time since reset and frame-level score/flash state.
module tb_score_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FLASH = 2;
  localparam int FRAME = 2 * DIV;

  logic clk;
  logic rst;
  score_scan_if sif ();

  score_scan_ctrl #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK),
    .FLASH_FRAMES (FLASH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int   m_t;
  int   m_pend [2];
  int   m_act  [2];
  int   m_winner;
  int   m_phase;
  int   m_fc;
  logic m_go_prev;
  logic go_lvl;

  task automatic check(input string name, input int act_v, input int exp_v);
    n_checks++;
    if (act_v != exp_v) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0d expected %0d", name, m_t, act_v, exp_v);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  function automatic int exp_en();
    int c;
    int s;
    int e;
    c = m_t % DIV;
    s = (m_t / DIV) % 2;
    e = (c >= BLANK) ? (1 << s) : 0;
    if (m_phase == 0) e = e & ~m_winner & 3;
    return e;
  endfunction

  function automatic int exp_score();
    return m_act[(m_t / DIV) % 2];
  endfunction

  function automatic int exp_fd();
    return ((m_t % FRAME) == FRAME - 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_t       = 0;
    m_pend[0] = 0; m_pend[1] = 0;
    m_act[0]  = 0; m_act[1]  = 0;
    m_winner  = 0;
    m_phase   = 1;
    m_fc      = 0;
    m_go_prev = 1'b0;
  endtask

  task automatic model_advance(input logic ld, input int a, input int b, input logic go);
    bit bnd;
    bnd = ((m_t % FRAME) == FRAME - 1);
    if (!go) begin
      m_winner = 0;
      m_phase  = 1;
      m_fc     = 0;
    end else begin
      if (!m_go_prev) begin
        if (m_act[0] > m_act[1])      m_winner = 1;
        else if (m_act[1] > m_act[0]) m_winner = 2;
        else                          m_winner = 3;
      end
      if (bnd) begin
        m_fc++;
        if (m_fc == FLASH) begin
          m_fc    = 0;
          m_phase = 1 - m_phase;
        end
      end
    end
    if (ld) begin
      m_pend[0] = sat(a);
      m_pend[1] = sat(b);
    end
    if (bnd) begin
      m_act[0] = m_pend[0];
      m_act[1] = m_pend[1];
    end
    m_go_prev = go;
    m_t++;
  endtask

  task automatic compare_model();
    check("model_en",    int'(sif.o_digit_en),   exp_en());
    check("model_score", int'(sif.o_score),      exp_score());
    check("model_fd",    int'(sif.o_frame_done), exp_fd());
  endtask

  task automatic step(input logic ld, input logic [3:0] a, input logic [3:0] b);
    sif.i_score_load = ld;
    sif.i_p1_score   = a;
    sif.i_p2_score   = b;
    sif.i_game_over  = go_lvl;
    model_advance(ld, int'(a), int'(b), go_lvl);
    @(posedge clk);
    #1;
    sif.i_score_load = 1'b0;
    compare_model();
  endtask

  task automatic idle_until(input int target);
    while (m_t < target) step(1'b0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    sif.i_score_load = 1'b0;
    sif.i_game_over  = go_lvl;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_en",    int'(sif.o_digit_en),   0);
    check("rst_score", int'(sif.o_score),      0);
    check("rst_fd",    int'(sif.o_frame_done), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] en;
    logic [3:0] score;
    logic       fd;
  } vec_t;

  vec_t vtab [32];

  initial begin
    // Scan/load timeline: load 3/7 in cycle 5, shown from the next frame
    for (int c = 0; c < 32; c++) begin
      int m;
      m = c % 16;
      vtab[c].ld    = (c == 5);
      vtab[c].p1    = 4'd3;
      vtab[c].p2    = 4'd7;
      vtab[c].en    = (m <= 1) ? 2'b00 : (m <= 7) ? 2'b01 : (m <= 9) ? 2'b00 : 2'b10;
      vtab[c].score = (c < 16) ? 4'd0 : (c < 24) ? 4'd3 : 4'd7;
      vtab[c].fd    = (m == 15);
    end

    rst              = 1'b1;
    go_lvl           = 1'b0;
    sif.i_p1_score   = 4'd0;
    sif.i_p2_score   = 4'd0;
    sif.i_score_load = 1'b0;
    sif.i_game_over  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset and scan + load timing from the table
    do_reset();
    for (int c = 0; c < 32; c++) begin
      check("tab_en",    int'(sif.o_digit_en),   int'(vtab[c].en));
      check("tab_score", int'(sif.o_score),      int'(vtab[c].score));
      check("tab_fd",    int'(sif.o_frame_done), int'(vtab[c].fd));
      step(vtab[c].ld, vtab[c].p1, vtab[c].p2);
    end

    // Saturation and last-wins within one frame
    do_reset();
    idle_until(3);
    step(1'b1, 4'd12, 4'd4);
    idle_until(6);
    step(1'b1, 4'd5, 4'd15);
    idle_until(16);
    check("sat_p1", int'(sif.o_score), 5);
    idle_until(24);
    check("sat_p2", int'(sif.o_score), 9);

    // Load exactly on the frame-done cycle bypasses pending
    do_reset();
    idle_until(15);
    check("bnd_fd", int'(sif.o_frame_done), 1);
    step(1'b1, 4'd2, 4'd6);
    check("bnd_p1", int'(sif.o_score), 2);
    idle_until(24);
    check("bnd_p2", int'(sif.o_score), 6);

    // Winner flash: 4/9, game over raised in frame 1
    do_reset();
    step(1'b1, 4'd4, 4'd9);
    idle_until(18);
    go_lvl = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      idle_until(f * FRAME + 4);
      check("flash_p1", int'(sif.o_digit_en), 1);
      idle_until(f * FRAME + 12);
      check("flash_p2", int'(sif.o_digit_en), (f == 3 || f == 4) ? 0 : 2);
    end

    // Tie: both digits blank in the off frames
    go_lvl = 1'b0;
    do_reset();
    step(1'b1, 4'd5, 4'd5);
    idle_until(18);
    go_lvl = 1'b1;
    idle_until(3 * FRAME + 4);
    check("tie_off_p1", int'(sif.o_digit_en), 0);
    idle_until(3 * FRAME + 12);
    check("tie_off_p2", int'(sif.o_digit_en), 0);
    idle_until(5 * FRAME + 4);
    check("tie_on_p1", int'(sif.o_digit_en), 1);

    // Reset during SHOW with game over still high
    idle_until(5 * FRAME + 12);
    do_reset();
    step(1'b0, 4'd0, 4'd0);
    check("rr_blank", int'(sif.o_digit_en), 0);
    step(1'b0, 4'd0, 4'd0);
    check("rr_show", int'(sif.o_digit_en), 1);
    check("rr_score", int'(sif.o_score), 0);
    go_lvl = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(149) == 0) go_lvl = ~go_lvl;
        step($urandom_range(5) == 0, 4'($urandom_range(15)), 4'($urandom_range(15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
